// File: rtl/graphics_pkg.sv
// Shared definitions for the graphics compositor: RGB332 palette and layer
// indices. Layer 0 has the highest priority, the maze is always the last layer.
package graphics_pkg;

   localparam logic [7:0] RED = 8'hE0;
   localparam logic [7:0] PNK = 8'hEF;
   localparam logic [7:0] CYN = 8'h1F;
   localparam logic [7:0] ORG = 8'hF4;
   localparam logic [7:0] YLW = 8'hFC;
   localparam logic [7:0] WHT = 8'hFF;
   localparam logic [7:0] CRM = 8'hF6;
   localparam logic [7:0] BLU = 8'h03;
   localparam logic [7:0] BLK = 8'h00;

   // An all-zero colour never wins the priority merge
   localparam logic [7:0] TRANSPARENT = BLK;

   typedef enum logic [2:0] {
      BLINKY = 3'd0,
      PINKY  = 3'd1,
      INKY   = 3'd2,
      CLYDE  = 3'd3,
      PACMAN = 3'd4,
      MAZE   = 3'd5
   } layer_e;

endpackage

// File: rtl/graphics_priority_mux.sv
// Combinational priority merge: the lowest-index layer that is both opaque
// (non-zero) and enabled supplies the colour. The hit vector flags every
// layer that is opaque and enabled at this pixel.
module graphics_priority_mux #(
   parameter int NUM_LAYERS = 6,
   parameter int COLOR_W    = 8
) (
   input  logic [NUM_LAYERS*COLOR_W-1:0] colors,
   input  logic [NUM_LAYERS-1:0]         mask,
   output logic [COLOR_W-1:0]            color,
   output logic [NUM_LAYERS-1:0]         hit
);

   logic found_s;

   // Scan layers in ascending index so the first visible one claims the pixel
   always_comb begin
      color   = {COLOR_W{1'b0}};
      hit     = {NUM_LAYERS{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if ((colors[i*COLOR_W +: COLOR_W] != {COLOR_W{1'b0}}) && mask[i]) begin
            hit[i] = 1'b1;
            if (!found_s) begin
               color   = colors[i*COLOR_W +: COLOR_W];
               found_s = 1'b1;
            end else begin
               found_s = 1'b1;
            end
         end else begin
            hit[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/graphics_compositor.sv
// Two-stage pixel pipeline. Stage 1 maps the VGA counters onto the rotated
// playfield and forms the maze RAM address; the sprite/maze sources answer one
// clock later, and stage 2 merges their colours by priority. Also produces the
// frame-start pulse, the ghost flash phase and (optionally) sprite collisions.
// Build option: define GRAPHICS_COLLISION_EN to capture per-frame overlaps with
// the pacman layer; otherwise the collision outputs are tied to zero.
module graphics_compositor
   import graphics_pkg::*;
#(
   parameter int NUM_LAYERS   = 6,
   parameter int COLOR_W      = 8,
   parameter int PAC_LAYER    = int'(PACMAN),
   parameter int XMAX         = 240,
   parameter int YMAX         = 320,
   parameter int YOFFSET      = 24,
   parameter int RAM_W        = 264,
   parameter int ADDR_W       = 16,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int FLASH_FRAMES = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [9:0]                    hc,
   input  logic [9:0]                    vc,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
   input  logic [NUM_LAYERS-1:0]         layer_enable_in,
   output logic [8:0]                    xpos,
   output logic [8:0]                    ypos,
   output logic [ADDR_W-1:0]             address,
   output logic [COLOR_W-1:0]            color,
   output logic                          frame_start,
   output logic                          flash,
   output logic [NUM_LAYERS-1:0]         collision_mask,
   output logic                          collision_valid
);

   localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   logic                  vis_s;
   logic                  row_s;
   logic [8:0]            x_next_s;
   logic [8:0]            y_next_s;
   logic [31:0]           y_full_s;
   logic [ADDR_W-1:0]     addr_next_s;
   logic                  frame_hit_s;
   logic                  active_d1_r;
   logic [NUM_LAYERS-1:0] enable_r;
   logic [CNT_W-1:0]      frame_cnt_r;
   logic [COLOR_W-1:0]    mux_color_s;
   logic [NUM_LAYERS-1:0] hit_s;

   // Rotate VGA counters into playfield coordinates; right border pins ypos to the last row
   always_comb begin
      row_s       = (vc < 10'(V_ACTIVE));
      vis_s       = row_s && (hc < 10'(H_ACTIVE));
      frame_hit_s = (hc == 10'd0) && (vc == 10'd0);
      if (row_s) begin
         x_next_s = 9'(XMAX - 1) - vc[9:1];
      end else begin
         x_next_s = 9'd0;
      end
      if (vis_s) begin
         y_next_s = hc[9:1];
      end else if (row_s) begin
         y_next_s = 9'(YMAX - 1);
      end else begin
         y_next_s = 9'd0;
      end
   end

   // Maze RAM only holds a window of ypos per row; outside it the address parks at all ones
   always_comb begin
      y_full_s = 32'(y_next_s);
      if ((y_full_s >= 32'(YOFFSET)) && (y_full_s < 32'(YOFFSET + RAM_W))) begin
         addr_next_s = ADDR_W'(32'(x_next_s) * 32'(RAM_W) + y_full_s - 32'(YOFFSET));
      end else begin
         addr_next_s = {ADDR_W{1'b1}};
      end
   end

   // Stage 1 registers; the layer mask is only sampled at a frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xpos        <= 9'd0;
         ypos        <= 9'd0;
         address     <= {ADDR_W{1'b1}};
         active_d1_r <= 1'b0;
         frame_start <= 1'b0;
         enable_r    <= {NUM_LAYERS{1'b1}};
      end else begin
         xpos        <= x_next_s;
         ypos        <= y_next_s;
         address     <= addr_next_s;
         active_d1_r <= vis_s;
         frame_start <= frame_hit_s;
         if (frame_hit_s) begin
            enable_r <= layer_enable_in;
         end else begin
            enable_r <= enable_r;
         end
      end
   end

   graphics_priority_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .COLOR_W    (COLOR_W)
   ) u_mux (
      .colors (layer_color),
      .mask   (enable_r),
      .color  (mux_color_s),
      .hit    (hit_s)
   );

   // Stage 2: composited pixel, forced transparent in blanking or when nothing is visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         color <= {COLOR_W{1'b0}};
      end else if (active_d1_r && (|hit_s)) begin
         color <= mux_color_s;
      end else begin
         color <= {COLOR_W{1'b0}};
      end
   end

   // Count frames and flip the flash phase every FLASH_FRAMES frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_r <= {CNT_W{1'b0}};
         flash       <= 1'b0;
      end else if (frame_start) begin
         if (frame_cnt_r == CNT_W'(FLASH_FRAMES - 1)) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            flash       <= ~flash;
         end else begin
            frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            flash       <= flash;
         end
      end else begin
         frame_cnt_r <= frame_cnt_r;
         flash       <= flash;
      end
   end

`ifdef GRAPHICS_COLLISION_EN
   // Pacman itself and the maze background never count as collisions
   localparam logic [NUM_LAYERS-1:0] COLL_SEL =
      ~((NUM_LAYERS'(1) << PAC_LAYER) | (NUM_LAYERS'(1) << (NUM_LAYERS - 1)));

   logic [NUM_LAYERS-1:0] new_hits_s;
   logic [NUM_LAYERS-1:0] sticky_r;

   // Layers overlapping a visible pacman pixel at this stage-2 slot
   always_comb begin
      if (active_d1_r && hit_s[PAC_LAYER]) begin
         new_hits_s = hit_s & COLL_SEL;
      end else begin
         new_hits_s = {NUM_LAYERS{1'b0}};
      end
   end

   // Accumulate hits over a frame; publish and restart at each frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_r        <= {NUM_LAYERS{1'b0}};
         collision_mask  <= {NUM_LAYERS{1'b0}};
         collision_valid <= 1'b0;
      end else if (frame_start) begin
         collision_mask  <= sticky_r;
         collision_valid <= 1'b1;
         sticky_r        <= new_hits_s;
      end else begin
         collision_mask  <= collision_mask;
         collision_valid <= 1'b0;
         sticky_r        <= sticky_r | new_hits_s;
      end
   end
`else
   assign collision_mask  = {NUM_LAYERS{1'b0}};
   assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_graphics_compositor.sv
// Self-checking bench for graphics_compositor: directed scenarios plus a
// randomized run against a behavioural model of the mapping/priority rules.
module tb_graphics_compositor;

   localparam int NL = 6;
   localparam int CW = 8;
   localparam int FF = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [9:0]    hc;
   logic [9:0]    vc;
   logic [NL*CW-1:0] layer_color;
   logic [NL-1:0] layer_enable_in;
   logic [8:0]    xpos;
   logic [8:0]    ypos;
   logic [15:0]   address;
   logic [7:0]    color;
   logic          frame_start;
   logic          flash;
   logic [NL-1:0] collision_mask;
   logic          collision_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   graphics_compositor #(.FLASH_FRAMES(FF)) dut (
      .clk             (clk),
      .rst             (rst),
      .hc              (hc),
      .vc              (vc),
      .layer_color     (layer_color),
      .layer_enable_in (layer_enable_in),
      .xpos            (xpos),
      .ypos            (ypos),
      .address         (address),
      .color           (color),
      .frame_start     (frame_start),
      .flash           (flash),
      .collision_mask  (collision_mask),
      .collision_valid (collision_valid)
   );

   // ---------------- reference model ----------------
   function automatic int exp_x(input int h, input int v);
      if (v < 480) return 239 - (v / 2);
      return 0;
   endfunction

   function automatic int exp_y(input int h, input int v);
      if (v < 480 && h < 640) return h / 2;
      if (v < 480) return 319;
      return 0;
   endfunction

   function automatic int exp_addr(input int x, input int y);
      if (y >= 24 && y < 24 + 264) return (x * 264 + y - 24) % 65536;
      return 65535;
   endfunction

   function automatic int exp_color(input logic [NL*CW-1:0] lc, input logic [NL-1:0] m,
                                    input int h, input int v);
      if (!(h < 640 && v < 480)) return 0;
      for (int i = 0; i < NL; i++) begin
         if (lc[i*CW +: CW] != 8'd0 && m[i]) return int'(lc[i*CW +: CW]);
      end
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      layer_color = '0;
      hc = 10'd0; vc = 10'd0;
      step();
      hc = 10'd1; vc = 10'd0;
      step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      hc = 10'd5; vc = 10'd5;
      layer_color = '0;
      layer_enable_in = 6'b111111;
      step();
      checks++;
      if (xpos !== 9'd0 || ypos !== 9'd0 || address !== 16'hFFFF || color !== 8'd0 ||
          frame_start !== 1'b0 || flash !== 1'b0 || collision_mask !== 6'd0 || collision_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset: x=%0d y=%0d addr=%0d col=%0h fs=%b fl=%b cm=%b cv=%b (want 0 0 65535 0 0 0 0 0)",
                  xpos, ypos, address, color, frame_start, flash, collision_mask, collision_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_mapping();
      hc = 10'd0; vc = 10'd0;
      step();
      checks++;
      if (xpos !== 9'd239 || ypos !== 9'd0 || address !== 16'd65535 || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL map_origin: x=%0d y=%0d addr=%0d fs=%b want 239 0 65535 1", xpos, ypos, address, frame_start);
      end
      hc = 10'd48; vc = 10'd0;
      step();
      checks++;
      if (ypos !== 9'd24 || address !== 16'd63096 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL map_yoffset: y=%0d addr=%0d fs=%b want 24 63096 0", ypos, address, frame_start);
      end
      hc = 10'd700; vc = 10'd10;
      step();
      checks++;
      if (xpos !== 9'd234 || ypos !== 9'd319 || address !== 16'd65535) begin
         errors++;
         $display("FAIL map_hblank: x=%0d y=%0d addr=%0d want 234 319 65535", xpos, ypos, address);
      end
      layer_color = {8'h03, 8'hFC, 8'h11, 8'h1F, 8'hEF, 8'hE0};
      hc = 10'd100; vc = 10'd100;
      step();
      checks++;
      if (color !== 8'd0) begin
         errors++;
         $display("FAIL blank_color: got %0h want 0", color);
      end
      layer_color = '0;
      hc = 10'd600; vc = 10'd500;
      step();
      checks++;
      if (xpos !== 9'd0 || ypos !== 9'd0 || address !== 16'hFFFF) begin
         errors++;
         $display("FAIL map_vblank: x=%0d y=%0d addr=%0d want 0 0 65535", xpos, ypos, address);
      end
   endtask

   task automatic test_priority();
      layer_color = '0;
      hc = 10'd100; vc = 10'd100;
      step();
      checks++;
      if (color !== 8'd0) begin
         errors++;
         $display("FAIL prio_early: got %0h want 0 after 1 clk", color);
      end
      layer_color = {8'h03, 8'hFC, 8'h00, 8'h1F, 8'hEF, 8'h00};
      hc = 10'd101;
      step();
      checks++;
      if (color !== 8'hEF) begin
         errors++;
         $display("FAIL prio_color: got %0h want ef", color);
      end
      layer_color = {8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      hc = 10'd102;
      step();
      checks++;
      if (color !== 8'h03) begin
         errors++;
         $display("FAIL prio_maze: got %0h want 03", color);
      end
      layer_color = '0;
   endtask

   task automatic test_enable();
      layer_enable_in = 6'b111101;
      hc = 10'd100; vc = 10'd100;
      layer_color = '0;
      step();
      layer_color = {8'h03, 8'hFC, 8'h00, 8'h1F, 8'hEF, 8'h00};
      hc = 10'd101;
      step();
      checks++;
      if (color !== 8'hEF) begin
         errors++;
         $display("FAIL enable_midframe: got %0h want ef", color);
      end
      frame_pulse();
      hc = 10'd100; vc = 10'd100;
      layer_color = '0;
      step();
      layer_color = {8'h03, 8'hFC, 8'h00, 8'h1F, 8'hEF, 8'h00};
      hc = 10'd101;
      step();
      checks++;
      if (color !== 8'h1F) begin
         errors++;
         $display("FAIL enable_newframe: got %0h want 1f", color);
      end
      layer_enable_in = 6'b111111;
      frame_pulse();
   endtask

   task automatic test_collision();
      frame_pulse();
      hc = 10'd20; vc = 10'd20;
      layer_color = '0;
      step();
      layer_color = {8'h00, 8'hFC, 8'h00, 8'h1F, 8'h00, 8'h00};
      hc = 10'd21;
      step();
      layer_color = '0;
      hc = 10'd22;
      step();
      hc = 10'd0; vc = 10'd0;
      step();
      hc = 10'd1;
      step();
`ifdef GRAPHICS_COLLISION_EN
      checks++;
      if (collision_valid !== 1'b1 || collision_mask !== 6'b000100) begin
         errors++;
         $display("FAIL coll_hit: valid=%b mask=%b want 1 000100", collision_valid, collision_mask);
      end
      step();
      checks++;
      if (collision_valid !== 1'b0 || collision_mask !== 6'b000100) begin
         errors++;
         $display("FAIL coll_pulse: valid=%b mask=%b want 0 000100", collision_valid, collision_mask);
      end
      hc = 10'd0; vc = 10'd0;
      step();
      hc = 10'd1;
      step();
      checks++;
      if (collision_valid !== 1'b1 || collision_mask !== 6'b000000) begin
         errors++;
         $display("FAIL coll_clear: valid=%b mask=%b want 1 000000", collision_valid, collision_mask);
      end
`else
      checks++;
      if (collision_valid !== 1'b0 || collision_mask !== 6'b000000) begin
         errors++;
         $display("FAIL coll_off: valid=%b mask=%b want 0 000000", collision_valid, collision_mask);
      end
`endif
   endtask

   task automatic test_random();
      logic [NL-1:0]    m;
      logic [NL*CW-1:0] lc_next;
      logic [NL*CW-1:0] lc_cur;
      int h, v, ph, pv;
      m = 6'($urandom);
      layer_enable_in = m;
      frame_pulse();
      lc_next = '0;
      ph = 0; pv = 0;
      for (int k = 0; k < 300; k++) begin
         h = int'($urandom_range(799));
         v = int'($urandom_range(524));
         if (h == 0 && v == 0) h = 1;
         hc = 10'(h); vc = 10'(v);
         lc_cur = lc_next;
         layer_color = lc_cur;
         for (int i = 0; i < NL; i++) begin
            if ($urandom_range(1) == 1) lc_next[i*CW +: CW] = 8'($urandom_range(255, 1));
            else lc_next[i*CW +: CW] = 8'd0;
         end
         step();
         checks++;
         if (xpos !== 9'(exp_x(h, v)) || ypos !== 9'(exp_y(h, v)) ||
             address !== 16'(exp_addr(exp_x(h, v), exp_y(h, v))) || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rnd_map hc=%0d vc=%0d: x=%0d y=%0d addr=%0d fs=%b want %0d %0d %0d 0",
                     h, v, xpos, ypos, address, frame_start,
                     exp_x(h, v), exp_y(h, v), exp_addr(exp_x(h, v), exp_y(h, v)));
         end
         if (k > 0) begin
            checks++;
            if (color !== 8'(exp_color(lc_cur, m, ph, pv))) begin
               errors++;
               $display("FAIL rnd_color hc=%0d vc=%0d: got %0h want %0h",
                        ph, pv, color, exp_color(lc_cur, m, ph, pv));
            end
         end
         ph = h; pv = v;
         layer_color = lc_next;
      end
      layer_color = '0;
      layer_enable_in = 6'b111111;
      frame_pulse();
   endtask

   task automatic test_flash();
      int n;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n = 0;
      for (int f = 0; f < 6; f++) begin
         frame_pulse();
         step();
         n++;
         checks++;
         if (flash !== 1'((n / FF) % 2)) begin
            errors++;
            $display("FAIL flash frame %0d: got %b want %0d", n, flash, (n / FF) % 2);
         end
      end
      hc = 10'd300; vc = 10'd200;
      step();
      rst = 1'b1;
      #2;
      checks++;
      if (flash !== 1'b0 || xpos !== 9'd0 || address !== 16'hFFFF || color !== 8'd0 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_midframe: fl=%b x=%0d addr=%0d col=%0h fs=%b want 0 0 65535 0 0",
                  flash, xpos, address, color, frame_start);
      end
      step();
      rst = 1'b0;
      hc = 10'd301;
      step();
      checks++;
      if (frame_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_nofs: fs=%b want 0", frame_start);
      end
      hc = 10'd0; vc = 10'd0;
      step();
      checks++;
      if (frame_start !== 1'b1) begin
         errors++;
         $display("FAIL rst_first_fs: fs=%b want 1", frame_start);
      end
      hc = 10'd1;
      step();
      checks++;
      if (flash !== 1'b0) begin
         errors++;
         $display("FAIL flash_after_rst: got %b want 0", flash);
      end
   endtask

   initial begin
      test_reset();
      test_mapping();
      test_priority();
      test_enable();
      test_collision();
      test_random();
      test_flash();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
